// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================
// Package : ssd_pkg
// Brief   : shared types and helpers for the seven-segment message scroller
// Rev     : 1.0
// ============================================================
package ssd_pkg;

    typedef logic [3:0] char_code_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam char_code_t c_blank_code = 4'hF;

    // (base + off) mod len, valid while base < len and off < len
    function automatic logic [3:0] wrap_add(input logic [3:0] base,
                                            input logic [3:0] off,
                                            input logic [4:0] len);
        logic [4:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= len) s = s - len;
        return s[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_msg_scroller_if.sv
`default_nettype none
// ============================================================
// Interface : ssd_msg_scroller_if
// Brief     : control, buffer-write and digit-code bundle of the scroller
// Rev       : 1.0
// ============================================================
interface ssd_msg_scroller_if;
    import ssd_pkg::*;

    logic       wr_en;
    logic [3:0] wr_addr;
    char_code_t wr_data;
    logic       start;
    logic       stop;
    logic       pause;
    logic       dir;
    char_code_t hex3_code;
    char_code_t hex2_code;
    char_code_t hex1_code;
    char_code_t hex0_code;
    logic [3:0] pos;
    logic       busy;
    logic       step_pulse;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, pause, dir,
        input  hex3_code, hex2_code, hex1_code, hex0_code, pos, busy, step_pulse
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, pause, dir,
        output hex3_code, hex2_code, hex1_code, hex0_code, pos, busy, step_pulse
    );

endinterface
`default_nettype wire

// File: rtl/ssd_tick_div.sv
`default_nettype none
// ============================================================
// Module : ssd_tick_div
// Brief  : enabled/clearable divider, one-cycle tick every TICK_DIV enabled cycles
// Rev    : 1.0
// ============================================================
module ssd_tick_div #(
    parameter int TICK_DIV = 50000000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_en,
    input  wire logic i_clr,
    output logic      o_tick
);

    localparam int                c_cnt_w = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Combinational so the owner can update its state on the wrapping edge
    assign o_tick = i_en && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ssd_msg_scroller.sv
`default_nettype none
// ============================================================
// Module : ssd_msg_scroller
// Brief  : scrolls a 4-digit window over a writable message buffer;
//          SSD_SCROLL_BOUNCE_EN selects ping-pong instead of wrap-around
// Rev    : 1.0
// ============================================================
module ssd_msg_scroller
    import ssd_pkg::*;
#(
    parameter int         MSG_LEN    = 8,
    parameter int         TICK_DIV   = 50000000,
    parameter char_code_t BLANK_CODE = c_blank_code
) (
    input wire logic          clk,
    input wire logic          reset,
    ssd_msg_scroller_if.slave bus
);

    localparam logic [4:0] c_len      = 5'(MSG_LEN);
    localparam logic [3:0] c_last_pos = 4'(MSG_LEN - 1);

    state_t     r_state;
    logic [3:0] r_pos;
    logic       r_busy;
    logic       r_step;
    // Sized to the full 4-bit address space; entries >= MSG_LEN are never written
    char_code_t r_msg [16];
    char_code_t r_hex [4];

    logic       w_cmd;
    logic       w_en;
    logic       w_tick;
    logic [3:0] w_pos_nxt;

    assign w_cmd = bus.stop | bus.start;
    // Releasing pause counts on the same edge that returns PAUSE to RUN
    assign w_en  = (r_state != IDLE) && !bus.pause && !w_cmd;

    ssd_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_en),
        .i_clr  (w_cmd),
        .o_tick (w_tick)
    );

`ifdef SSD_SCROLL_BOUNCE_EN
    localparam logic [3:0] c_turn_pos = 4'(MSG_LEN - 4);

    logic r_bdir;
    logic w_turn;

    always_comb begin
        w_turn    = r_bdir ? (r_pos == 4'd0) : (r_pos == c_turn_pos);
        w_pos_nxt = (r_bdir ^ w_turn) ? r_pos - 4'd1 : r_pos + 4'd1;
    end
`else
    always_comb begin
        if (bus.dir) w_pos_nxt = (r_pos == 4'd0) ? c_last_pos : r_pos - 4'd1;
        else         w_pos_nxt = (r_pos == c_last_pos) ? 4'd0 : r_pos + 4'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pos   <= 4'd0;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
`ifdef SSD_SCROLL_BOUNCE_EN
            r_bdir  <= 1'b0;
`endif
        end else begin
            r_step <= 1'b0;
            if (bus.stop) begin
                r_state <= IDLE;
                r_pos   <= 4'd0;
                r_busy  <= 1'b0;
`ifdef SSD_SCROLL_BOUNCE_EN
                r_bdir  <= 1'b0;
`endif
            end else if (bus.start) begin
                r_state <= RUN;
                r_pos   <= 4'd0;
                r_busy  <= 1'b1;
`ifdef SSD_SCROLL_BOUNCE_EN
                r_bdir  <= 1'b0;
`endif
            end else if (r_state != IDLE) begin
                if (bus.pause) begin
                    r_state <= PAUSE;
                end else begin
                    r_state <= RUN;
                    if (w_tick) begin
                        r_step <= 1'b1;
                        r_pos  <= w_pos_nxt;
`ifdef SSD_SCROLL_BOUNCE_EN
                        r_bdir <= r_bdir ^ w_turn;
`endif
                    end
                end
            end
        end
    end

    // Window registers read the current pos/buffer, so any change shows one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_msg[i] <= BLANK_CODE;
            for (int k = 0; k < 4; k++)  r_hex[k] <= BLANK_CODE;
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_hex[k] <= r_msg[wrap_add(r_pos, 4'(k), c_len)];
            end
            if (bus.wr_en && ({1'b0, bus.wr_addr} < c_len)) begin
                r_msg[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.hex3_code  = r_hex[0];
    assign bus.hex2_code  = r_hex[1];
    assign bus.hex1_code  = r_hex[2];
    assign bus.hex0_code  = r_hex[3];
    assign bus.pos        = r_pos;
    assign bus.busy       = r_busy;
    assign bus.step_pulse = r_step;

endmodule
`default_nettype wire

// File: tb/tb_ssd_msg_scroller.sv
`default_nettype none
// ============================================================
// Module : tb_ssd_msg_scroller
// Brief  : directed + randomized checks of ssd_msg_scroller against a behavioural model
// Rev    : 1.0
// ============================================================
module tb_ssd_msg_scroller;
    import ssd_pkg::*;

    localparam int MSG_LEN  = 8;
    localparam int TICK_DIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ssd_msg_scroller_if bus ();

    ssd_msg_scroller #(
        .MSG_LEN    (MSG_LEN),
        .TICK_DIV   (TICK_DIV),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference: plain integers, window recomputed with modulo
    int m_state;  // 0 idle, 1 run, 2 pause
    int m_pos, m_cnt, m_bdir;
    bit m_busy, m_step;
    int m_msg [MSG_LEN];
    int m_hex [4];

    function automatic int next_pos(input int p, input bit d);
`ifdef SSD_SCROLL_BOUNCE_EN
        if (m_bdir == 0) begin
            if (p == MSG_LEN - 4) begin m_bdir = 1; return p - 1; end
            return p + 1;
        end
        if (p == 0) begin m_bdir = 0; return 1; end
        return p - 1;
`else
        return d ? (p + MSG_LEN - 1) % MSG_LEN : (p + 1) % MSG_LEN;
`endif
    endfunction

    task automatic model_edge();
        int nh [4];
        for (int k = 0; k < 4; k++) nh[k] = m_msg[(m_pos + k) % MSG_LEN];
        m_step = 0;
        if (reset) begin
            m_state = 0; m_pos = 0; m_cnt = 0; m_bdir = 0; m_busy = 0;
            for (int i = 0; i < MSG_LEN; i++) m_msg[i] = 15;
            for (int k = 0; k < 4; k++) m_hex[k] = 15;
            return;
        end
        for (int k = 0; k < 4; k++) m_hex[k] = nh[k];
        if (bus.wr_en && int'(bus.wr_addr) < MSG_LEN) m_msg[int'(bus.wr_addr)] = int'(bus.wr_data);
        if (bus.stop) begin
            m_state = 0; m_pos = 0; m_cnt = 0; m_bdir = 0; m_busy = 0;
        end else if (bus.start) begin
            m_state = 1; m_pos = 0; m_cnt = 0; m_bdir = 0; m_busy = 1;
        end else if (m_state != 0) begin
            if (bus.pause) m_state = 2;
            else begin
                m_state = 1;
                if (m_cnt == TICK_DIV - 1) begin
                    m_cnt  = 0;
                    m_step = 1;
                    m_pos  = next_pos(m_pos, bus.dir);
                end else m_cnt++;
            end
        end
    endtask

    function automatic logic [15:0] dut_hex();
        return {bus.hex3_code, bus.hex2_code, bus.hex1_code, bus.hex0_code};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("hex", dut_hex(), {4'(m_hex[0]), 4'(m_hex[1]), 4'(m_hex[2]), 4'(m_hex[3])});
            chk("pos", bus.pos, m_pos);
            chk("busy_step", {bus.busy, bus.step_pulse}, {m_busy, m_step});
        end
    endtask

    task automatic wait_pos(input int target, input int max_cyc);
        int i = 0;
        while (m_pos != target && i < max_cyc) begin cyc(1); i++; end
        chk("wait_pos", bus.pos, target);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    endtask

    initial begin
        int w, nstep;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.dir = 0;
        m_state = 0; m_pos = 0; m_cnt = 0; m_bdir = 0; m_busy = 0; m_step = 0;
        for (int i = 0; i < MSG_LEN; i++) m_msg[i] = 15;
        for (int k = 0; k < 4; k++) m_hex[k] = 15;

        cyc(2);
        chk("reset_hex", dut_hex(), 16'hFFFF);
        reset = 1'b0;

        for (int i = 0; i < MSG_LEN; i++) begin
            bus.wr_en = 1; bus.wr_addr = 4'(i); bus.wr_data = 4'(i + 1); cyc(1);
        end
        bus.wr_en = 0; cyc(1);
        chk("load_window", dut_hex(), 16'h1234);
        chk("load_idle", {bus.busy, bus.pos}, 5'h00);

        bus.dir = 0;
        pulse_start();
`ifdef SSD_SCROLL_BOUNCE_EN
        begin
            int seq [10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
            for (int j = 0; j < 10; j++) begin
                w = 0;
                do begin cyc(1); w++; end while (!m_step && w < 20);
                chk("bounce_pos", bus.pos, seq[j]);
            end
        end
`else
        wait_pos(6, 40);
        cyc(1);
        chk("window_pos6", dut_hex(), 16'h7812);
        wait_pos(0, 20);
        bus.dir = 1;
        wait_pos(7, 10);
        cyc(1);
        chk("window_pos7", dut_hex(), 16'h8123);
`endif

        // Pause with the count at 2: frozen, then two counting cycles to the step
        bus.dir = 0;
        pulse_start();
        cyc(2);
        bus.pause = 1; nstep = 0;
        for (int i = 0; i < 10; i++) begin cyc(1); nstep += int'(bus.step_pulse); end
        chk("pause_no_step", nstep, 0);
        bus.pause = 0; w = 0;
        do begin cyc(1); w++; end while (!bus.step_pulse && w < 10);
        chk("pause_resume_gap", w, 2);

        // Write lands on the same edge as the 0->1 step
        pulse_start();
        cyc(3);
        bus.wr_en = 1; bus.wr_addr = 4'd1; bus.wr_data = 4'hA; cyc(1);
        bus.wr_en = 0; cyc(1);
        chk("write_on_step", bus.hex3_code, 4'hA);
        bus.wr_en = 1; bus.wr_addr = 4'd9; bus.wr_data = 4'h0; cyc(1);
        bus.wr_en = 0; cyc(1);
        chk("write_oob", dut_hex(), 16'hA345);

        bus.start = 1; bus.stop = 1; cyc(1);
        bus.start = 0; bus.stop = 0;
        chk("stop_wins", {bus.busy, bus.pos}, 5'h00);
        cyc(3);

        for (int i = 0; i < 700; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            bus.start = ($urandom_range(0, 29) == 0);
            bus.stop  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 11) == 0) bus.pause = ~bus.pause;
            if ($urandom_range(0, 9) == 0)  bus.dir   = ~bus.dir;
            bus.wr_en   = ($urandom_range(0, 4) == 0);
            bus.wr_addr = 4'($urandom_range(0, 15));
            bus.wr_data = 4'($urandom_range(0, 15));
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
